// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// The sequencer is the master; the datapath and IR are the slave.
interface mc_control_fsm_if;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       Zero;
   logic       MemReady;
   logic       PCEn;
   logic       IorD;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSrc;
   logic [2:0] ALUControl;
   logic       IllegalOp;

   modport master (
      input  Opcode, Funct, Zero, MemReady,
      output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
      output RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl, IllegalOp
   );

   modport slave (
      output Opcode, Funct, Zero, MemReady,
      input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
      input  RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl, IllegalOp
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: Moore FSM with registered
// per-state controls, stalling every memory state on MemReady.
module mc_control_fsm #(
   parameter int STATE_W = 4
) (
   input  logic            CLK,
   input  logic            RST,
   mc_control_fsm_if.master bus
);

   typedef enum logic [STATE_W-1:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SEL_ADD = 2'd0;
   localparam logic [1:0] SEL_SUB = 2'd1;
   localparam logic [1:0] SEL_FN  = 2'd2;

   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] alusel;
      logic       fetch;
      logic       dec;
      logic       br;
      logic       jmp;
   } ctl_t;

   state_t state_q;
   state_t nxt;
   ctl_t   ctl_q;
   logic   run;

   function automatic logic legal(input logic [5:0] op);
      return op == OP_R || op == OP_LW || op == OP_SW ||
             op == OP_BEQ || op == OP_ADDI || op == OP_J;
   endfunction

   function automatic state_t next_of(
      input state_t     s,
      input logic [5:0] op,
      input logic       rdy
   );
      state_t n;
      n = FETCH;
      case (s)
         FETCH:  n = rdy ? DECODE : FETCH;
         DECODE: begin
            unique case (1'b1)
               op == OP_LW,
               op == OP_SW:   n = MEMADR;
               op == OP_R:    n = EXEC;
               op == OP_BEQ:  n = BRANCH;
               op == OP_ADDI: n = ADDIEX;
               op == OP_J:    n = JUMP;
               default:       n = FETCH;
            endcase
         end
         MEMADR: n = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  n = rdy ? MEMWB : MEMRD;
         MEMWR:  n = rdy ? FETCH : MEMWR;
         EXEC:   n = ALUWB;
         ADDIEX: n = ADDIWB;
         default: n = FETCH;
      endcase
      return n;
   endfunction

   function automatic ctl_t out_of(input state_t s);
      ctl_t c;
      c = '0;
      c.alusel = SEL_ADD;
      case (s)
         FETCH: begin
            c.alusrcb = 2'b01;
            c.fetch   = 1'b1;
         end
         DECODE: begin
            c.alusrcb = 2'b11;
            c.dec     = 1'b1;
         end
         MEMADR, ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         MEMRD: c.iord = 1'b1;
         MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         EXEC: begin
            c.alusrca = 1'b1;
            c.alusel  = SEL_FN;
         end
         ALUWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         BRANCH: begin
            c.alusrca = 1'b1;
            c.alusel  = SEL_SUB;
            c.pcsrc   = 2'b01;
            c.br      = 1'b1;
         end
         ADDIWB: c.regwrite = 1'b1;
         JUMP: begin
            c.pcsrc = 2'b10;
            c.jmp   = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] fn);
      logic [2:0] a;
      case (fn)
         6'b100010: a = ALU_SUB;
         6'b100100: a = ALU_AND;
         6'b100101: a = ALU_OR;
         6'b101010: a = ALU_SLT;
         default:   a = ALU_ADD;
      endcase
      return a;
   endfunction

   assign nxt = next_of(state_q, bus.Opcode, bus.MemReady);

   // Advance state and register the controls of the state being entered.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= FETCH;
         ctl_q   <= out_of(FETCH);
      end else begin
         state_q <= nxt;
         ctl_q   <= out_of(nxt);
      end
   end

   // Enables are killed during reset and in any unused encoding.
   assign run = RST & (state_q <= JUMP);

   assign bus.PCEn = run & ((ctl_q.fetch & bus.MemReady) |
                            (ctl_q.br & bus.Zero) | ctl_q.jmp);
   assign bus.IRWrite   = run & ctl_q.fetch & bus.MemReady;
   assign bus.MemWrite  = run & ctl_q.memwrite;
   assign bus.RegWrite  = run & ctl_q.regwrite;
   assign bus.IllegalOp = run & ctl_q.dec & ~legal(bus.Opcode);
   assign bus.IorD      = ctl_q.iord;
   assign bus.RegDst    = ctl_q.regdst;
   assign bus.MemtoReg  = ctl_q.memtoreg;
   assign bus.ALUSrcA   = ctl_q.alusrca;
   assign bus.ALUSrcB   = ctl_q.alusrcb;
   assign bus.PCSrc     = ctl_q.pcsrc;
   assign bus.ALUControl =
      (ctl_q.alusel == SEL_SUB) ? ALU_SUB :
      (ctl_q.alusel == SEL_FN)  ? funct_alu(bus.Funct) : ALU_ADD;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for the multicycle control sequencer: directed instruction
// table, reset corner cases and a randomized cycle-level model.
module tb_mc_control_fsm;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   mc_control_fsm_if bus ();

   mc_control_fsm #(.STATE_W(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       pcen;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] aluctl;
      logic       illegal;
   } ctl_t;

   ctl_t act;
   assign act = {bus.PCEn, bus.IorD, bus.MemWrite, bus.IRWrite,
                 bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA,
                 bus.ALUSrcB, bus.PCSrc, bus.ALUControl, bus.IllegalOp};

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, exp);
      end
   endtask

   // Directed instruction records
   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         stall;
      int         len;
      int         rw;
      int         mw;
      int         io;
      int         il;
      int         pcx;
      int         m2r;
      int         rd;
      logic [1:0] ps;
      logic [2:0] alu;
   } vec_t;

   vec_t tbl[$];

   task automatic run_vec(input vec_t v, input int idx);
      int n = 0, stall = v.stall;
      int rw = 0, mw = 0, io = 0, il = 0, pcx = 0, m2r = 0, rd = 0, irw = 0;
      logic [1:0] ps = 2'b00;
      logic [2:0] alu = 3'b000;
      bit done = 0;
      string t;
      t = $sformatf("vec%0d", idx);
      bus.Opcode = v.op;
      bus.Funct  = v.fn;
      bus.Zero   = v.z;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge CLK);
         if (bus.IorD && stall > 0) begin
            bus.MemReady = 1'b0;
            stall--;
         end else begin
            bus.MemReady = 1'b1;
         end
         #1;
         if (c > 0 && bus.ALUSrcB == 2'b01) begin
            done = 1;
            bus.MemReady = 1'b0;
         end else begin
            n++;
            rw  += int'(bus.RegWrite);
            mw  += int'(bus.MemWrite);
            io  += int'(bus.IorD);
            il  += int'(bus.IllegalOp);
            m2r += int'(bus.MemtoReg & bus.RegWrite);
            rd  += int'(bus.RegDst);
            irw += int'(bus.IRWrite);
            if (bus.PCEn && bus.ALUSrcB != 2'b01) begin
               pcx++;
               ps = bus.PCSrc;
            end
            if (bus.ALUSrcA && bus.ALUSrcB == 2'b00 && bus.PCSrc == 2'b00)
               alu = bus.ALUControl;
         end
         @(posedge CLK);
         #1;
      end
      check({t, "_len"}, n, v.len);
      check({t, "_regwr"}, rw, v.rw);
      check({t, "_memwr"}, mw, v.mw);
      check({t, "_iord"}, io, v.io);
      check({t, "_illegal"}, il, v.il);
      check({t, "_pcen"}, pcx, v.pcx);
      check({t, "_memtoreg"}, m2r, v.m2r);
      check({t, "_regdst"}, rd, v.rd);
      check({t, "_irwrite"}, irw, 1);
      if (v.pcx > 0) check({t, "_pcsrc"}, ps, v.ps);
      if (v.op == 6'b000000) check({t, "_alu"}, alu, v.alu);
   endtask

   // Cycle-level reference model
   typedef enum {
      S_F, S_D, S_MA, S_MR, S_MB, S_MW, S_EX, S_AW, S_BR, S_AX, S_AB, S_J
   } ph_t;

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
   endfunction

   function automatic logic [2:0] exp_alu(input logic [5:0] fn);
      case (fn)
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h2a:   return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   function automatic bit waits(input ph_t p);
      return p == S_F || p == S_MR || p == S_MW;
   endfunction

   function automatic ctl_t exp_of(input ph_t p, input logic m,
                                   input logic z, input logic [5:0] op,
                                   input logic [5:0] fn);
      ctl_t e;
      e = '0;
      e.aluctl = 3'b010;
      case (p)
         S_F:  begin e.alusrcb = 2'b01; e.pcen = m; e.irwrite = m; end
         S_D:  begin e.alusrcb = 2'b11; e.illegal = !is_legal(op); end
         S_MA, S_AX: begin e.alusrca = 1; e.alusrcb = 2'b10; end
         S_MR: e.iord = 1;
         S_MB: begin e.memtoreg = 1; e.regwrite = 1; end
         S_MW: begin e.iord = 1; e.memwrite = 1; end
         S_EX: begin e.alusrca = 1; e.aluctl = exp_alu(fn); end
         S_AW: begin e.regdst = 1; e.regwrite = 1; end
         S_BR: begin
            e.alusrca = 1; e.aluctl = 3'b110;
            e.pcsrc = 2'b01; e.pcen = z;
         end
         S_AB: e.regwrite = 1;
         S_J:  begin e.pcsrc = 2'b10; e.pcen = 1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
   logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

   initial begin
      ph_t q[$];
      ph_t p;
      logic m, z;
      ctl_t e;
      bit hit;

      bus.Opcode   = 6'h3f;
      bus.Funct    = 6'h00;
      bus.Zero     = 1'b0;
      bus.MemReady = 1'b1;

      // Reset held with memory ready
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("rst_enables", {bus.PCEn, bus.IRWrite, bus.RegWrite,
               bus.MemWrite, bus.IllegalOp}, 5'b0);
         check("rst_srcb", bus.ALUSrcB, 2'b01);
      end
      RST = 1'b1;
      #1;
      check("rel_irwrite", {bus.IRWrite, bus.PCEn}, 2'b11);
      @(posedge CLK);
      #1;
      check("rel_decode", bus.ALUSrcB, 2'b11);
      check("rel_illegal", bus.IllegalOp, 1'b1);
      @(posedge CLK);
      #1;

      tbl.push_back('{6'h23, 6'h00, 0, 2, 7, 1, 0, 3, 0, 0, 1, 0, 2'b00, 3'b010});
      tbl.push_back('{6'h23, 6'h00, 0, 0, 5, 1, 0, 1, 0, 0, 1, 0, 2'b00, 3'b010});
      tbl.push_back('{6'h00, 6'h20, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010});
      tbl.push_back('{6'h00, 6'h22, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110});
      tbl.push_back('{6'h00, 6'h24, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000});
      tbl.push_back('{6'h00, 6'h25, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001});
      tbl.push_back('{6'h00, 6'h2a, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111});
      tbl.push_back('{6'h04, 6'h00, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0, 2'b01, 3'b010});
      tbl.push_back('{6'h04, 6'h00, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010});
      tbl.push_back('{6'h2b, 6'h00, 0, 1, 5, 0, 2, 2, 0, 0, 0, 0, 2'b00, 3'b010});
      tbl.push_back('{6'h02, 6'h00, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 2'b10, 3'b010});
      tbl.push_back('{6'h3f, 6'h00, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b010});
      tbl.push_back('{6'h08, 6'h00, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010});

      foreach (tbl[i]) run_vec(tbl[i], i);

      // Reset dropped while a store is stalled
      bus.Opcode   = 6'h2b;
      bus.MemReady = 1'b1;
      hit = 0;
      for (int c = 0; c < 10 && !hit; c++) begin
         if (bus.MemWrite) hit = 1;
         else begin
            @(posedge CLK);
            #1;
         end
      end
      bus.MemReady = 1'b0;
      check("swrst_pre", bus.MemWrite, 1'b1);
      #2;
      RST = 1'b0;
      #1;
      check("swrst_memwrite", bus.MemWrite, 1'b0);
      check("swrst_fetch", {bus.ALUSrcB, bus.IorD}, 3'b010);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;

      // Randomized run against the cycle model
      q.push_back(S_F);
      for (int c = 0; c < 4000; c++) begin
         p = q[0];
         m = waits(p) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
         z = 1'($urandom_range(0, 1));
         bus.MemReady = m;
         bus.Zero     = z;
         @(negedge CLK);
         e = exp_of(p, m, z, bus.Opcode, bus.Funct);
         check($sformatf("rnd_c%0d_ph%0d", c, p), act, e);
         @(posedge CLK);
         #1;
         if (!(waits(p) && !m)) begin
            void'(q.pop_front());
            if (p == S_F) begin
               int k;
               k = $urandom_range(0, 6);
               bus.Opcode = (k < 6) ? ops[k] : 6'($urandom_range(0, 63));
               bus.Funct  = $urandom_range(0, 1) ?
                            fns[$urandom_range(0, 4)] :
                            6'($urandom_range(0, 63));
               q.push_back(S_D);
               case (bus.Opcode)
                  6'h23: begin q.push_back(S_MA); q.push_back(S_MR); q.push_back(S_MB); end
                  6'h2b: begin q.push_back(S_MA); q.push_back(S_MW); end
                  6'h00: begin q.push_back(S_EX); q.push_back(S_AW); end
                  6'h04: q.push_back(S_BR);
                  6'h08: begin q.push_back(S_AX); q.push_back(S_AB); end
                  6'h02: q.push_back(S_J);
                  default: ;
               endcase
               q.push_back(S_F);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
